mips_data_bus_bridge: RTL
=========================

// Module: mips_data_bus_bridge
// PURPOSE
// - Sits between mips_cpu_harvard data port and the word-only external data memory bus.
// - Accepts one CPU load/store at a time, stalls the CPU, drives a waitrequest memory bus.
// - Merges partial (byte/half) stores via read-modify-write; enforces a waitrequest timeout.
// PARAMETERS
// - MAX_WAIT  default 255  cycles waitrequest may stay high per bus phase before abort.
// - CNT_W     default 8    width of wait counter; must hold MAX_WAIT.
// PORTS
// - clk              in   1   system clock, all state on posedge
// - reset            in   1   synchronous, active-high
// - cpu_address      in   32  byte address; [1:0] ignored for bus, used by CPU only
// - cpu_read         in   1   load request, held until cpu_stall low
// - cpu_write        in   1   store request, held until cpu_stall low
// - cpu_byteenable   in   4   lanes written on store; [0] = bits 7:0
// - cpu_writedata    in   32  store data, lane-aligned
// - cpu_readdata     out  32  load result, valid in DONE cycle
// - cpu_stall        out  1   CPU must hold state while high
// - bus_error        out  1   sticky; set on timeout or read+write together
// - mem_address      out  32  {addr[31:2],2'b00}
// - mem_read         out  1   bus read strobe
// - mem_write        out  1   bus write strobe
// - mem_writedata    out  32  bus write data
// - mem_readdata     in   32  bus read data, valid when mem_read && !mem_waitrequest
// - mem_waitrequest  in   1   slave not ready; strobes/address/data held while high
// - mem_byteenable   out  4   only when MEM_BYTEENABLE_EN defined
// BEHAVIOUR
// - Reset: state IDLE; mem_read=mem_write=0, mem_address=0, mem_writedata=0,
//   cpu_readdata=0, bus_error=0, wait counter 0. Mid-transaction reset aborts; strobes low next edge.
// - States: IDLE, RD, RMW_RD, RMW_WR, WR, DONE.
// - IDLE: no request -> stay, cpu_stall=0. Request -> latch address/data/byteenable,
//   cpu_stall=1 combinationally same cycle; next:
//   read -> RD; write be=1111 -> WR; write be=0000 -> DONE (no bus access);
//   other be -> RMW_RD (WR if MEM_BYTEENABLE_EN).
// - read && write both high: treated as write; bus_error set.
// - RD/RMW_RD: mem_read=1. On !mem_waitrequest: RD captures cpu_readdata<=mem_readdata -> DONE;
//   RMW_RD merges latched lanes over mem_readdata into mem_writedata -> RMW_WR.
// - WR/RMW_WR: mem_write=1; on !mem_waitrequest -> DONE.
// - Strobes registered: asserted first cycle after entering bus state, dropped the cycle after accept.
// - Min latency: full-word load/store 3 cycles stalled (IDLE, bus, DONE w/ stall low);
//   RMW store 4 cycles; each waitrequest cycle adds 1.
// - DONE: cpu_stall=0 for exactly one cycle, cpu_readdata stable; request inputs ignored; -> IDLE.
// - cpu_readdata holds last load value until next load completes.
// - Wait counter: clears on entering each bus state, +1 per cycle with waitrequest high;
//   reaching MAX_WAIT -> strobes drop, bus_error=1, cpu_readdata=32'hFFFF_FFFF on reads, -> DONE.
// - bus_error cleared only by reset.
// CONFIGURATION
// - MEM_BYTEENABLE_EN defined: mem_byteenable port exists, = latched be on writes, 4'b1111 on reads;
//   partial stores go straight to WR, RMW states unreachable.
// - Undefined: no mem_byteenable port; partial stores always use RMW_RD -> RMW_WR.
// TESTING
// - Load 0x100, mem word 0xDEADBEEF, waitrequest 0 -> mem_read 1 cycle, addr 0x100,
//   cpu_readdata=0xDEADBEEF, stall low on cycle 3.
// - Store be=1111 data 0x12345678 to 0x204, waitrequest high 2 cycles -> mem_write held 3 cycles,
//   addr 0x204 stable, DONE on cycle 5.
// - Store be=0010 data 0x0000AB00, mem word 0x11223344 -> RMW writes 0x1122AB44
//   (with MEM_BYTEENABLE_EN: single write, mem_byteenable=0010).
// - Store be=0000 -> no mem strobe, stall released after 2 cycles.
// - Load with waitrequest stuck high -> abort after MAX_WAIT, bus_error=1, cpu_readdata=0xFFFFFFFF.
// - Reset asserted during RMW_WR -> next cycle IDLE, mem_write=0, bus_error=0, cpu_stall=0.

Source files
------------

// File: rtl/mips_data_bus_bridge_if.sv
// CPU data-port and word-wide memory-bus interfaces for mips_data_bus_bridge.
// MEM_BYTEENABLE_EN adds mem_byteenable to the memory bus.
interface mips_cpu_data_if;
    logic [31:0] cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [3:0]  cpu_byteenable;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_stall;

    modport master (
        output cpu_address, cpu_read, cpu_write, cpu_byteenable, cpu_writedata,
        input  cpu_readdata, cpu_stall
    );
    modport slave (
        input  cpu_address, cpu_read, cpu_write, cpu_byteenable, cpu_writedata,
        output cpu_readdata, cpu_stall
    );
endinterface

interface mips_mem_bus_if;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
`ifdef MEM_BYTEENABLE_EN
    logic [3:0]  mem_byteenable;
`endif

    modport master (
`ifdef MEM_BYTEENABLE_EN
        output mem_byteenable,
`endif
        output mem_address, mem_read, mem_write, mem_writedata,
        input  mem_readdata, mem_waitrequest
    );
    modport slave (
`ifdef MEM_BYTEENABLE_EN
        input  mem_byteenable,
`endif
        input  mem_address, mem_read, mem_write, mem_writedata,
        output mem_readdata, mem_waitrequest
    );
endinterface

// File: rtl/mips_data_bus_bridge.sv
// Single-outstanding CPU data-port to word-only waitrequest bus bridge with RMW partial stores.
// Defining MEM_BYTEENABLE_EN drives mem_byteenable and sends partial stores straight to WR.
module mips_data_bus_bridge #(
    parameter int unsigned MAX_WAIT = 255,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    mips_cpu_data_if.slave   cpu,
    mips_mem_bus_if.master   mem,
    output logic             bus_error
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_RMW_RD, S_RMW_WR, S_WR, S_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [3:0]       r_be;
    logic [31:0]      r_wdata;
    logic [31:0]      r_mem_address;
    logic [31:0]      r_mem_writedata;
    logic [31:0]      r_cpu_readdata;
    logic             r_mem_read;
    logic             r_mem_write;
    logic             r_bus_error;
`ifdef MEM_BYTEENABLE_EN
    logic [3:0]       r_mem_be;
`endif

    logic             w_req;
    logic             w_timeout;
    logic             w_stall;
    logic [31:0]      w_merged;

    assign w_req     = cpu.cpu_read || cpu.cpu_write;
    // Abort on the cycle the counter would reach MAX_WAIT with waitrequest still high.
    assign w_timeout = mem.mem_waitrequest && (r_wait_cnt == CNT_W'(MAX_WAIT - 1));

    always_comb begin
        w_merged = mem.mem_readdata;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_be[i]) begin
                w_merged[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:                          w_stall = w_req;
            S_RD, S_RMW_RD, S_RMW_WR, S_WR:  w_stall = 1'b1;
            default:                         w_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_wait_cnt      <= '0;
            r_be            <= '0;
            r_wdata         <= '0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
            r_cpu_readdata  <= '0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_bus_error     <= 1'b0;
`ifdef MEM_BYTEENABLE_EN
            r_mem_be        <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_mem_address   <= {cpu.cpu_address[31:2], 2'b00};
                        r_be            <= cpu.cpu_byteenable;
                        r_wdata         <= cpu.cpu_writedata;
                        r_mem_writedata <= cpu.cpu_writedata;
                        r_wait_cnt      <= '0;
                        if (cpu.cpu_read && cpu.cpu_write) begin
                            r_bus_error <= 1'b1;
                        end
                        if (cpu.cpu_write) begin
                            if (cpu.cpu_byteenable == 4'b1111) begin
                                r_mem_write <= 1'b1;
                                r_state     <= S_WR;
`ifdef MEM_BYTEENABLE_EN
                                r_mem_be    <= cpu.cpu_byteenable;
`endif
                            end else if (cpu.cpu_byteenable == 4'b0000) begin
                                r_state     <= S_DONE;
                            end else begin
`ifdef MEM_BYTEENABLE_EN
                                r_mem_write <= 1'b1;
                                r_mem_be    <= cpu.cpu_byteenable;
                                r_state     <= S_WR;
`else
                                r_mem_read  <= 1'b1;
                                r_state     <= S_RMW_RD;
`endif
                            end
                        end else begin
                            r_mem_read <= 1'b1;
                            r_state    <= S_RD;
`ifdef MEM_BYTEENABLE_EN
                            r_mem_be   <= 4'b1111;
`endif
                        end
                    end
                end
                S_RD: begin
                    if (!mem.mem_waitrequest) begin
                        r_cpu_readdata <= mem.mem_readdata;
                        r_mem_read     <= 1'b0;
                        r_state        <= S_DONE;
                    end else if (w_timeout) begin
                        r_cpu_readdata <= 32'hFFFF_FFFF;
                        r_mem_read     <= 1'b0;
                        r_bus_error    <= 1'b1;
                        r_state        <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_RMW_RD: begin
                    if (!mem.mem_waitrequest) begin
                        r_mem_writedata <= w_merged;
                        r_mem_read      <= 1'b0;
                        r_mem_write     <= 1'b1;
                        r_wait_cnt      <= '0;
                        r_state         <= S_RMW_WR;
                    end else if (w_timeout) begin
                        r_mem_read  <= 1'b0;
                        r_bus_error <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_RMW_WR, S_WR: begin
                    if (!mem.mem_waitrequest) begin
                        r_mem_write <= 1'b0;
                        r_state     <= S_DONE;
                    end else if (w_timeout) begin
                        r_mem_write <= 1'b0;
                        r_bus_error <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu.cpu_readdata  = r_cpu_readdata;
    assign cpu.cpu_stall     = w_stall;
    assign mem.mem_address   = r_mem_address;
    assign mem.mem_read      = r_mem_read;
    assign mem.mem_write     = r_mem_write;
    assign mem.mem_writedata = r_mem_writedata;
`ifdef MEM_BYTEENABLE_EN
    assign mem.mem_byteenable = r_mem_be;
`endif
    assign bus_error         = r_bus_error;

endmodule
